bheap_pq: RTL and testbench

Parametrised, bus-mapped binary-heap priority queue for the bheap benchmark suite. It generalises the fixed two-level scan heap to 2^LEVELS−1 entries of WIDTH bits. It supports insert, extract-max and clear commands issued over the global RD/WR/Addr/DataIn/DataOut bus. A single sequential engine handles ordering, performing one heap-level compare/swap per cycle.

---
 rtl/bheap_pq.sv | 240 ++++++++++++++++++++++++
 tb/tb_bheap_pq.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bheap_pq.sv
// bheap_pq: bus-mapped binary-heap priority queue.
// The heap holds 2^LEVELS-1 keys of WIDTH bits, stored 1-based in mem[1..N].
// One sequential engine restores heap order after each insert or extract,
// handling one level (compare, then optional swap) per clock.
// Register window, four words starting at BASE:
//   write: +0 insert key, +1 extract, +3 clear
//   read : +0 Count, +1 Result, +2 {Error, Busy, Full, Empty}
// Build option: define BHEAP_PQ_MIN_EN to build a min-heap; the default
// build is a max-heap.
module bheap_pq #(
    parameter int          WIDTH  = 32,
    parameter int          LEVELS = 4,
    parameter logic [14:0] BASE   = 15'd0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        RD,
    input  logic        WR,
    input  logic [14:0] Addr,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        Busy
);

    localparam int N = (1 << LEVELS) - 1;
    localparam logic [LEVELS-1:0] ROOT = 1;

    typedef enum logic [1:0] {
        IDLE,
        SIFT_UP,
        SIFT_DOWN
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  mem [1:N];
    logic [LEVELS-1:0] count;
    logic [LEVELS-1:0] idx;
    logic [WIDTH-1:0]  result;
    logic              error;

    // Ordering predicate: true when key a belongs above key b in the heap.
    function automatic logic better(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef BHEAP_PQ_MIN_EN
        return a < b;
`else
        return a > b;
`endif
    endfunction

    // Window decode; the offset wraps so the window may sit anywhere in the 15-bit space.
    logic [14:0] offset;
    logic        inWindow;
    logic [1:0]  wordSel;
    logic        wrInsert;
    logic        wrExtract;
    logic        wrClear;
    logic        empty;
    logic        full;

    assign offset    = Addr - BASE;
    assign inWindow  = (offset[14:2] == '0);
    assign wordSel   = offset[1:0];
    assign wrInsert  = WR && inWindow && (wordSel == 2'd0);
    assign wrExtract = WR && inWindow && (wordSel == 2'd1);
    assign wrClear   = WR && inWindow && (wordSel == 2'd3);
    assign empty     = (count == '0);
    assign full      = (count == LEVELS'(N));
    assign Busy      = (state != IDLE);

    // Index arithmetic; child indices carry one extra bit so 2i+1 cannot wrap.
    logic [LEVELS-1:0] countInc;
    logic [LEVELS-1:0] parentIdx;
    logic [LEVELS:0]   leftWide;
    logic [LEVELS:0]   rightWide;
    logic              leftValid;
    logic              rightValid;
    logic [LEVELS-1:0] leftIdx;
    logic [LEVELS-1:0] rightIdx;
    logic [LEVELS-1:0] pickIdx;

    assign countInc   = count + 1'b1;
    assign parentIdx  = idx >> 1;
    assign leftWide   = {idx, 1'b0};
    assign rightWide  = {idx, 1'b1};
    assign leftValid  = (leftWide  <= {1'b0, count});
    assign rightValid = (rightWide <= {1'b0, count});
    // A child index that passes its valid check is <= Count, so it fits in LEVELS bits.
    assign leftIdx    = leftWide[LEVELS-1:0];
    assign rightIdx   = rightWide[LEVELS-1:0];

    // Per-cycle sift decisions and the two memory write ports they need.
    logic              upSwap;
    logic              downSwap;
    logic              we0;
    logic              we1;
    logic [LEVELS-1:0] addr0;
    logic [LEVELS-1:0] addr1;
    logic [WIDTH-1:0]  data0;
    logic [WIDTH-1:0]  data1;

    // Select the swap (or load) for this cycle; a swap writes two entries at once.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned and infers a latch.
        pickIdx  = leftIdx;
        upSwap   = 1'b0;
        downSwap = 1'b0;
        we0      = 1'b0;
        we1      = 1'b0;
        addr0    = ROOT;
        addr1    = ROOT;
        data0    = '0;
        data1    = '0;

        // Right child only wins when strictly better, so ties go left.
        if (rightValid && better(mem[rightIdx], mem[leftIdx])) begin
            pickIdx = rightIdx;
        end

        if (state == SIFT_UP) begin
            upSwap = (idx != ROOT) && better(mem[idx], mem[parentIdx]);
        end
        if (state == SIFT_DOWN) begin
            downSwap = leftValid && better(mem[pickIdx], mem[idx]);
        end

        if (state == IDLE && wrInsert && !full) begin
            we0   = 1'b1;
            addr0 = countInc;
            data0 = DataIn[WIDTH-1:0];
        end else if (state == IDLE && wrExtract && !empty) begin
            we0   = 1'b1;
            addr0 = ROOT;
            data0 = mem[count];
        end else if (upSwap) begin
            we0   = 1'b1;
            addr0 = idx;
            data0 = mem[parentIdx];
            we1   = 1'b1;
            addr1 = parentIdx;
            data1 = mem[idx];
        end else if (downSwap) begin
            we0   = 1'b1;
            addr0 = idx;
            data0 = mem[pickIdx];
            we1   = 1'b1;
            addr1 = pickIdx;
            data1 = mem[idx];
        end
    end

    // Heap storage; entries above Count are never read, so the array needs no reset.
    always_ff @(posedge Clk) begin
        // NOTE: memories are left unreset so they map onto plain RAM/register-file cells.
        if (we0) begin
            mem[addr0] <= data0;
        end
        if (we1) begin
            mem[addr1] <= data1;
        end
    end

    // Command acceptance, sift sequencing, Count/Result/Error bookkeeping.
    always_ff @(posedge Clk) begin
        // NOTE: state is updated with non-blocking assignments so every read in this block sees pre-edge values.
        if (Reset) begin
            state  <= IDLE;
            count  <= '0;
            idx    <= '0;
            result <= '0;
            error  <= 1'b0;
        end else if (wrClear) begin
            state <= IDLE;
            count <= '0;
            error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (wrInsert) begin
                        if (full) begin
                            error <= 1'b1;
                        end else begin
                            count <= countInc;
                            idx   <= countInc;
                            state <= SIFT_UP;
                        end
                    end else if (wrExtract) begin
                        if (empty) begin
                            error  <= 1'b1;
                            result <= '0;
                        end else begin
                            result <= mem[ROOT];
                            count  <= count - 1'b1;
                            idx    <= ROOT;
                            state  <= SIFT_DOWN;
                        end
                    end
                end
                SIFT_UP: begin
                    if (wrInsert || wrExtract) begin
                        error <= 1'b1;
                    end
                    if (upSwap) begin
                        idx <= parentIdx;
                    end else begin
                        state <= IDLE;
                    end
                end
                SIFT_DOWN: begin
                    if (wrInsert || wrExtract) begin
                        error <= 1'b1;
                    end
                    if (downSwap) begin
                        idx <= pickIdx;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Read mux; pre-edge values, zero-extended to the 32-bit bus.
    logic [31:0] readData;

    always_comb begin
        readData = '0;
        case (wordSel)
            2'd0:    readData = 32'(count);
            2'd1:    readData = 32'(result);
            2'd2:    readData = {28'b0, error, Busy, full, empty};
            default: readData = '0;
        endcase
    end

    assign DataOut = (RD && inWindow) ? readData : 32'bz;

endmodule

// File: tb/tb_bheap_pq.sv
// Directed bench for bheap_pq (LEVELS=3, window at 0x0100).
module tb_bheap_pq;

    localparam logic [14:0] BASE = 15'h0100;
    localparam logic [14:0] A_INS = BASE;
    localparam logic [14:0] A_EXT = BASE + 15'd1;
    localparam logic [14:0] A_STS = BASE + 15'd2;
    localparam logic [14:0] A_CLR = BASE + 15'd3;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        RD = 1'b0;
    logic        WR = 1'b0;
    logic [14:0] Addr = '0;
    logic [31:0] DataIn = '0;
    wire  [31:0] DataOut;
    logic        Busy;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] rd;

    // Weak pull so an undriven bus reads as all ones.
    pullup (DataOut);

    bheap_pq #(
        .WIDTH (32),
        .LEVELS(3),
        .BASE  (BASE)
    ) dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .RD     (RD),
        .WR     (WR),
        .Addr   (Addr),
        .DataIn (DataIn),
        .DataOut(DataOut),
        .Busy   (Busy)
    );

    always #5 Clk = ~Clk;

    task automatic busWrite(input logic [14:0] a, input logic [31:0] d);
        @(negedge Clk);
        Addr   = a;
        DataIn = d;
        WR     = 1'b1;
        @(posedge Clk);
        #1;
        WR = 1'b0;
    endtask

    task automatic busRead(input logic [14:0] a, output logic [31:0] d);
        @(negedge Clk);
        Addr = a;
        RD   = 1'b1;
        #1;
        d  = DataOut;
        RD = 1'b0;
    endtask

    // Counts Busy-high cycles after a command; a stuck Busy is a failure.
    task automatic measureBusy(input string tag, output int n);
        n = 0;
        @(negedge Clk);
        while (Busy && n < 20) begin
            n++;
            @(negedge Clk);
        end
        checks++;
        if (Busy) begin
            failures++;
            $display("FAIL %s_busy_timeout: Busy=%0b after %0d cycles, required 0", tag, Busy, n);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        Reset = 1'b0;
        checks++;
        if (Busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy: got %0b expected 0", Busy);
        end
        busRead(A_STS, rd);
        checks++;
        if (rd !== 32'h1) begin
            failures++;
            $display("FAIL reset_status: got 0x%0h expected 0x1", rd);
        end
        busRead(A_INS, rd);
        checks++;
        if (rd !== 32'h0) begin
            failures++;
            $display("FAIL reset_count: got 0x%0h expected 0x0", rd);
        end
        @(negedge Clk);
        Addr = A_STS;
        #1;
        checks++;
        if (DataOut !== 32'hFFFF_FFFF && DataOut !== 32'hzzzz_zzzz) begin
            failures++;
            $display("FAIL idle_bus_z: got 0x%0h expected undriven", DataOut);
        end
        busRead(BASE + 15'd4, rd);
        checks++;
        if (rd !== 32'hFFFF_FFFF && rd !== 32'hzzzz_zzzz) begin
            failures++;
            $display("FAIL out_of_window_z: got 0x%0h expected undriven", rd);
        end
    endtask

    task automatic test_ordering();
        int keys[4]    = '{5, 9, 3, 7};
        int busyLen[4] = '{1, 2, 1, 2};
        int expOut[4]  = '{9, 7, 5, 3};
        int n;
        for (int k = 0; k < 4; k++) begin
            busWrite(A_INS, keys[k]);
            checks++;
            if (Busy !== 1'b1) begin
                failures++;
                $display("FAIL insert%0d_busy_rise: got %0b expected 1", k, Busy);
            end
            measureBusy("ordering_insert", n);
            checks++;
            if (n != busyLen[k]) begin
                failures++;
                $display("FAIL insert%0d_busy_len: got %0d cycles expected %0d", k, n, busyLen[k]);
            end
        end
        busRead(A_INS, rd);
        checks++;
        if (rd !== 32'd4) begin
            failures++;
            $display("FAIL ordering_count: got %0d expected 4", rd);
        end
        for (int k = 0; k < 4; k++) begin
            busWrite(A_EXT, 32'h0);
            busRead(A_EXT, rd);
            checks++;
            if (rd !== 32'(expOut[k])) begin
                failures++;
                $display("FAIL extract%0d_result: got %0d expected %0d", k, rd, expOut[k]);
            end
            measureBusy("ordering_extract", n);
        end
        busRead(A_STS, rd);
        checks++;
        if (rd !== 32'h1) begin
            failures++;
            $display("FAIL ordering_final_status: got 0x%0h expected 0x1", rd);
        end
    endtask

    task automatic test_full();
        int n;
        for (int k = 1; k <= 7; k++) begin
            busWrite(A_INS, 32'(k));
            measureBusy("full_fill", n);
        end
        busRead(A_STS, rd);
        checks++;
        if (rd !== 32'h2) begin
            failures++;
            $display("FAIL full_status: got 0x%0h expected 0x2", rd);
        end
        busWrite(A_INS, 32'd100);
        busRead(A_INS, rd);
        checks++;
        if (rd !== 32'd7) begin
            failures++;
            $display("FAIL full_reject_count: got %0d expected 7", rd);
        end
        busRead(A_STS, rd);
        checks++;
        if (rd !== 32'hA) begin
            failures++;
            $display("FAIL full_reject_status: got 0x%0h expected 0xA", rd);
        end
        busWrite(A_EXT, 32'h0);
        busRead(A_EXT, rd);
        checks++;
        if (rd !== 32'd7) begin
            failures++;
            $display("FAIL full_extract: got %0d expected 7", rd);
        end
        measureBusy("full_extract", n);
        busWrite(A_CLR, 32'h0);
        busRead(A_STS, rd);
        checks++;
        if (rd !== 32'h1) begin
            failures++;
            $display("FAIL full_clear_status: got 0x%0h expected 0x1", rd);
        end
    endtask

    task automatic test_empty_extract();
        busWrite(A_EXT, 32'h0);
        busRead(A_EXT, rd);
        checks++;
        if (rd !== 32'h0) begin
            failures++;
            $display("FAIL empty_extract_result: got %0d expected 0", rd);
        end
        busRead(A_STS, rd);
        checks++;
        if (rd !== 32'h9) begin
            failures++;
            $display("FAIL empty_extract_status: got 0x%0h expected 0x9", rd);
        end
        busWrite(A_CLR, 32'h0);
        busRead(A_STS, rd);
        checks++;
        if (rd !== 32'h1) begin
            failures++;
            $display("FAIL empty_clear_status: got 0x%0h expected 0x1", rd);
        end
    endtask

    task automatic test_busy_reject();
        int n;
        busWrite(A_INS, 32'd4);
        measureBusy("reject_first", n);
        busWrite(A_INS, 32'd8);
        busWrite(A_INS, 32'd6);
        measureBusy("reject_sift", n);
        busRead(A_INS, rd);
        checks++;
        if (rd !== 32'd2) begin
            failures++;
            $display("FAIL busy_reject_count: got %0d expected 2", rd);
        end
        busRead(A_STS, rd);
        checks++;
        if (rd !== 32'h8) begin
            failures++;
            $display("FAIL busy_reject_status: got 0x%0h expected 0x8", rd);
        end
        busWrite(A_EXT, 32'h0);
        checks++;
        if (Busy !== 1'b1) begin
            failures++;
            $display("FAIL sift_down_busy: got %0b expected 1", Busy);
        end
        busRead(A_EXT, rd);
        checks++;
        if (rd !== 32'd8) begin
            failures++;
            $display("FAIL busy_reject_extract: got %0d expected 8", rd);
        end
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        checks++;
        if (Busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_sift_reset_busy: got %0b expected 0", Busy);
        end
        busRead(A_INS, rd);
        checks++;
        if (rd !== 32'd0) begin
            failures++;
            $display("FAIL mid_sift_reset_count: got %0d expected 0", rd);
        end
        busRead(A_EXT, rd);
        checks++;
        if (rd !== 32'd0) begin
            failures++;
            $display("FAIL mid_sift_reset_result: got %0d expected 0", rd);
        end
        busRead(A_STS, rd);
        checks++;
        if (rd !== 32'h1) begin
            failures++;
            $display("FAIL mid_sift_reset_status: got 0x%0h expected 0x1", rd);
        end
    endtask

    task automatic test_rd_wr_same();
        int n;
        @(negedge Clk);
        Addr   = A_INS;
        DataIn = 32'd42;
        WR     = 1'b1;
        RD     = 1'b1;
        #1;
        checks++;
        if (DataOut !== 32'd0) begin
            failures++;
            $display("FAIL rdwr_pre_edge_count: got %0d expected 0", DataOut);
        end
        @(posedge Clk);
        #1;
        checks++;
        if (DataOut !== 32'd1) begin
            failures++;
            $display("FAIL rdwr_post_edge_count: got %0d expected 1", DataOut);
        end
        WR = 1'b0;
        RD = 1'b0;
        measureBusy("rdwr", n);
        busWrite(A_STS, 32'hFF);
        busWrite(BASE + 15'd4, 32'd77);
        busWrite(15'h0000, 32'd55);
        busRead(A_INS, rd);
        checks++;
        if (rd !== 32'd1) begin
            failures++;
            $display("FAIL ignored_writes_count: got %0d expected 1", rd);
        end
        busRead(A_STS, rd);
        checks++;
        if (rd !== 32'h0) begin
            failures++;
            $display("FAIL ignored_writes_status: got 0x%0h expected 0x0", rd);
        end
        busWrite(A_EXT, 32'h0);
        busRead(A_EXT, rd);
        checks++;
        if (rd !== 32'd42) begin
            failures++;
            $display("FAIL rdwr_extract: got %0d expected 42", rd);
        end
        measureBusy("rdwr_extract", n);
    endtask

    task automatic test_order_variant();
        int keys[3] = '{5, 9, 3};
`ifdef BHEAP_PQ_MIN_EN
        int expOut[3] = '{3, 5, 9};
`else
        int expOut[3] = '{9, 5, 3};
`endif
        int n;
        for (int k = 0; k < 3; k++) begin
            busWrite(A_INS, keys[k]);
            measureBusy("variant_insert", n);
        end
        for (int k = 0; k < 3; k++) begin
            busWrite(A_EXT, 32'h0);
            busRead(A_EXT, rd);
            checks++;
            if (rd !== 32'(expOut[k])) begin
                failures++;
                $display("FAIL variant_extract%0d: got %0d expected %0d", k, rd, expOut[k]);
            end
            measureBusy("variant_extract", n);
        end
        busRead(A_STS, rd);
        checks++;
        if (rd !== 32'h1) begin
            failures++;
            $display("FAIL variant_final_status: got 0x%0h expected 0x1", rd);
        end
    endtask

    initial begin
        test_reset();
        test_ordering();
        test_full();
        test_empty_extract();
        test_busy_reject();
        test_rd_wr_same();
        test_order_variant();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
